// File: rtl/frame_rate_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_rate_pkg
//  Purpose  : Shared definitions for the frame-tick generator. Holds the
//             rate interval table, the speed-code clamp, the per-channel
//             RUN/PAUSED state encoding and the default speed code.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package frame_rate_pkg;

    // Per-channel run state.
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } ch_state_e;

    // Speed code used at reset and substituted for code 0.
    localparam logic [2:0] C_DEFAULT_SPEED = 3'd3;

    // Frame interval in clock ticks, indexed by clamped speed code 1..6.
    localparam logic [6:1][31:0] C_IVL_TABLE = {
        32'd80_000,     // 6
        32'd120_000,    // 5
        32'd200_000,    // 4
        32'd400_000,    // 3
        32'd800_000,    // 2
        32'd1_600_000   // 1
    };

    // Map the full 3-bit code space onto the 1..6 table range.
    function automatic logic [2:0] clamp_speed(input logic [2:0] code);
        logic [2:0] res;
        case (code)
            3'd0:    res = C_DEFAULT_SPEED;
            3'd7:    res = 3'd6;
            default: res = code;
        endcase
        return res;
    endfunction

    // Unshifted interval for any raw speed code.
    function automatic logic [31:0] interval_ticks(input logic [2:0] code);
        return C_IVL_TABLE[clamp_speed(code)];
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_rate_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_rate_gen_if
//  Purpose  : Control/status bundle of the multi-channel frame-tick
//             generator. The master (controller) drives the per-channel
//             requests; the slave (generator) drives pulses, indices and
//             pause status.
//  Signals  : speed[NUM_CH*3]  pause/resume/restart/step[NUM_CH]
//             next_frame[NUM_CH]  frame_idx[NUM_CH*FRAME_W]  paused[NUM_CH]
//  Revision : 1.0  initial release
// ============================================================================
interface frame_rate_gen_if #(
    parameter int NUM_CH  = 4,
    parameter int FRAME_W = 8
);
    logic [NUM_CH*3-1:0]       speed;
    logic [NUM_CH-1:0]         pause;
    logic [NUM_CH-1:0]         resume;
    logic [NUM_CH-1:0]         restart;
    logic [NUM_CH-1:0]         step;
    logic [NUM_CH-1:0]         next_frame;
    logic [NUM_CH*FRAME_W-1:0] frame_idx;
    logic [NUM_CH-1:0]         paused;

    modport master (
        output speed, pause, resume, restart, step,
        input  next_frame, frame_idx, paused
    );

    modport slave (
        input  speed, pause, resume, restart, step,
        output next_frame, frame_idx, paused
    );
endinterface
`default_nettype wire

// File: rtl/frame_rate_ch.sv
`default_nettype none
// ============================================================================
//  Module   : frame_rate_ch
//  Purpose  : One frame-tick channel: RUN/PAUSED FSM, rate counter, latched
//             interval and wrapping frame index. A new speed is only taken
//             at a frame boundary (or restart/step) so periods never glitch.
//  Ports    : clk, rst (async, active-high)
//             speed_i[3], pause_i, resume_i, restart_i, step_i (step only
//             when FRAME_RATE_GEN_STEP_EN is defined)
//             next_frame_o, frame_idx_o[FRAME_W], paused_o
//  Options  : FRAME_RATE_GEN_STEP_EN - single-frame advance while paused
//  Revision : 1.0  initial release
// ============================================================================
module frame_rate_ch
    import frame_rate_pkg::*;
#(
    parameter int CNT_W          = 24,
    parameter int FRAME_W        = 8,
    parameter int INTERVAL_SHIFT = 0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [2:0]         speed_i,
    input  wire logic               pause_i,
    input  wire logic               resume_i,
    input  wire logic               restart_i,
`ifdef FRAME_RATE_GEN_STEP_EN
    input  wire logic               step_i,
`endif
    output logic                    next_frame_o,
    output logic [FRAME_W-1:0]      frame_idx_o,
    output logic                    paused_o
);

    localparam logic [CNT_W-1:0] C_RST_IVL =
        CNT_W'(interval_ticks(C_DEFAULT_SPEED) >> INTERVAL_SHIFT);

    ch_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   ivl_q;
    logic [FRAME_W-1:0] idx_q;
    logic               next_frame_q;

    logic [CNT_W-1:0]   ivl_d;
    logic [FRAME_W-1:0] idx_d;

    // Interval that would be latched from the speed code presented now.
    assign ivl_d = CNT_W'(interval_ticks(speed_i) >> INTERVAL_SHIFT);
    // Natural wrap of the FRAME_W-bit index.
    assign idx_d = idx_q + FRAME_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            ivl_q        <= C_RST_IVL;
            idx_q        <= '0;
            next_frame_q <= 1'b0;
        end else begin
            next_frame_q <= 1'b0;
            if (restart_i) begin
                // Restart keeps the run/paused state; only the timeline resets.
                cnt_q <= '0;
                idx_q <= '0;
                ivl_q <= ivl_d;
            end else begin
                unique case (state_q)
                    ST_RUN: begin
                        if (pause_i && !resume_i) begin
                            state_q <= ST_PAUSED;
                        end
                        // Counting follows the registered state, so the edge
                        // that samples pause still advances the count.
                        if (cnt_q == ivl_q) begin
                            cnt_q        <= '0;
                            next_frame_q <= 1'b1;
                            idx_q        <= idx_d;
                            ivl_q        <= ivl_d;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_PAUSED: begin
                        if (resume_i && !pause_i) begin
                            state_q <= ST_RUN;
                        end
`ifdef FRAME_RATE_GEN_STEP_EN
                        if (step_i) begin
                            cnt_q        <= '0;
                            next_frame_q <= 1'b1;
                            idx_q        <= idx_d;
                            ivl_q        <= ivl_d;
                        end
`endif
                    end
                endcase
            end
        end
    end

    assign next_frame_o = next_frame_q;
    assign frame_idx_o  = idx_q;
    assign paused_o     = (state_q == ST_PAUSED);

endmodule
`default_nettype wire

// File: rtl/frame_rate_gen.sv
`default_nettype none
// ============================================================================
//  Module   : frame_rate_gen
//  Purpose  : Multi-channel frame-tick generator. NUM_CH independent
//             channels each emit a 1-cycle next_frame pulse at a rate picked
//             from the shared interval table, with pause/resume/restart and
//             a wrapping frame index.
//  Ports    : clk, rst (async, active-high)
//             bus (frame_rate_gen_if.slave): speed, pause, resume, restart,
//             step in; next_frame, frame_idx, paused out
//  Options  : FRAME_RATE_GEN_STEP_EN - honour step while a channel is paused;
//             when undefined the step signal is not used
//  Revision : 1.0  initial release
// ============================================================================
module frame_rate_gen
    import frame_rate_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 24,
    parameter int FRAME_W        = 8,
    parameter int INTERVAL_SHIFT = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    frame_rate_gen_if.slave   bus
);

    wire [NUM_CH-1:0]         w_next_frame;
    wire [NUM_CH-1:0]         w_paused;
    wire [NUM_CH*FRAME_W-1:0] w_frame_idx;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        frame_rate_ch #(
            .CNT_W          (CNT_W),
            .FRAME_W        (FRAME_W),
            .INTERVAL_SHIFT (INTERVAL_SHIFT)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .speed_i      (bus.speed[3*g +: 3]),
            .pause_i      (bus.pause[g]),
            .resume_i     (bus.resume[g]),
            .restart_i    (bus.restart[g]),
`ifdef FRAME_RATE_GEN_STEP_EN
            .step_i       (bus.step[g]),
`endif
            .next_frame_o (w_next_frame[g]),
            .frame_idx_o  (w_frame_idx[FRAME_W*g +: FRAME_W]),
            .paused_o     (w_paused[g])
        );
    end

`ifndef FRAME_RATE_GEN_STEP_EN
    // Step is part of the bus but has no effect in this build.
    wire w_step_unused = ^bus.step;
`endif

    assign bus.next_frame = w_next_frame;
    assign bus.frame_idx  = w_frame_idx;
    assign bus.paused     = w_paused;

endmodule
`default_nettype wire
